// File: rtl/pru_pkg.sv
// Shared types for the PRU command sequencer: shape codes, the queued command
// record and the sequencer state encoding.
package pru_pkg;

    // Shape codes as seen by the PRU; codes 2 and 3 both select bitmap.
    typedef enum logic [1:0] {
        SHAPE_RECT = 2'd0,
        SHAPE_CIRC = 2'd1,
        SHAPE_BMP  = 2'd2
    } shape_e;

    // One queued draw command, 61 bits. The shape is kept as a raw 2-bit
    // code so that code 3 reaches the PRU unchanged.
    typedef struct packed {
        logic [1:0]  shape;
        logic [1:0]  color;
        logic [9:0]  col;
        logic [8:0]  row;
        logic [9:0]  width;
        logic [8:0]  height_radius;
        logic [18:0] bitmap_addr;
    } pru_cmd_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_DONE = 3'd2,
        RELEASE   = 3'd3
    } seq_state_e;

endpackage

// File: rtl/pru_cmd_fifo.sv
// Single-clock command FIFO with first-word fall-through read data and a
// synchronous flush that empties it at the next edge.
module pru_cmd_fifo
    import pru_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  pru_cmd_t               push_data,
    input  logic                   pop,
    output pru_cmd_t               pop_data,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    pru_cmd_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage write; entries are data only and need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; DEPTH is a power of 2 so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pru_cmd_sequencer.sv
// Queues draw commands from the MMIO decoder and issues them one at a time to
// the PRU over its start/busy/done handshake, with timeout recovery.
module pru_cmd_sequencer
    import pru_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 524288,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_shape,
    input  logic [1:0]             cmd_color,
    input  logic [9:0]             cmd_col,
    input  logic [8:0]             cmd_row,
    input  logic [9:0]             cmd_width,
    input  logic [8:0]             cmd_height_radius,
    input  logic [18:0]            cmd_bitmap_addr,
    input  logic                   flush,
    input  logic                   err_clr,
    output logic                   pru_start,
    output logic [1:0]             pru_shape_select,
    output logic [1:0]             pru_color,
    output logic [9:0]             pru_col,
    output logic [8:0]             pru_row,
    output logic [9:0]             pru_width,
    output logic [8:0]             pru_height_radius,
    output logic [18:0]            pru_bitmap_addr,
    input  logic                   pru_busy,
    input  logic                   pru_done,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic                   seq_idle,
    output logic                   err_timeout,
    output logic [CNT_W-1:0]       cmds_done
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    seq_state_e    state;
    seq_state_e    state_nxt;
    pru_cmd_t      push_cmd;
    pru_cmd_t      head_cmd;
    pru_cmd_t      field_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          finish;
    logic          tmo_abort;
    logic [TW-1:0] tmo_cnt;

    assign cmd_ready = !fifo_full && !flush;
    assign seq_idle  = (state == IDLE) && fifo_empty;

    // Gather the MMIO fields into one FIFO entry.
    always_comb begin
        push_cmd.shape         = cmd_shape;
        push_cmd.color         = cmd_color;
        push_cmd.col           = cmd_col;
        push_cmd.row           = cmd_row;
        push_cmd.width         = cmd_width;
        push_cmd.height_radius = cmd_height_radius;
        push_cmd.bitmap_addr   = cmd_bitmap_addr;
    end

    pru_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid && cmd_ready),
        .push_data (push_cmd),
        .pop       (pop),
        .pop_data  (head_cmd),
        .flush     (flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (queue_count)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a done seen together with the timeout counts as done.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        finish    = 1'b0;
        tmo_abort = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !pru_busy) begin
                    pop       = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (pru_done) begin
                    finish    = 1'b1;
                    state_nxt = RELEASE;
                end else if (tmo_cnt == TMO_LAST) begin
                    finish    = 1'b1;
                    tmo_abort = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!pru_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered start: raised by the edge leaving LAUNCH, held through WAIT_DONE,
    // and dropped on the edge into RELEASE so the PRU cannot re-trigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pru_start <= 1'b0;
        end else begin
            pru_start <= (state_nxt == WAIT_DONE);
        end
    end

    // Command field registers change only when an entry is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_q <= '0;
        end else if (pop) begin
            field_q <= head_cmd;
        end
    end

    assign pru_shape_select  = field_q.shape;
    assign pru_color         = field_q.color;
    assign pru_col           = field_q.col;
    assign pru_row           = field_q.row;
    assign pru_width         = field_q.width;
    assign pru_height_radius = field_q.height_radius;
    assign pru_bitmap_addr   = field_q.bitmap_addr;

    // Timeout counter: zeroed in LAUNCH so it starts at 0 on entry to WAIT_DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == LAUNCH) begin
            tmo_cnt <= '0;
        end else if (state == WAIT_DONE) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout <= 1'b0;
        end else if (tmo_abort) begin
            err_timeout <= 1'b1;
        end else if (err_clr) begin
            err_timeout <= 1'b0;
        end
    end

    // Completed-or-aborted command counter, wrapping at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmds_done <= '0;
        end else if (finish) begin
            cmds_done <= cmds_done + 1'b1;
        end
    end

endmodule

// File: tb/tb_pru_cmd_sequencer.sv
// Scoreboard bench for pru_cmd_sequencer: accepted commands are queued as
// expectations, a monitor pops and compares them on every PRU launch.
module tb_pru_cmd_sequencer;
    import pru_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_shape = '0;
    logic [1:0]  cmd_color = '0;
    logic [9:0]  cmd_col = '0;
    logic [8:0]  cmd_row = '0;
    logic [9:0]  cmd_width = '0;
    logic [8:0]  cmd_height_radius = '0;
    logic [18:0] cmd_bitmap_addr = '0;
    logic        flush = 1'b0;
    logic        err_clr = 1'b0;
    logic        pru_start;
    logic [1:0]  pru_shape_select;
    logic [1:0]  pru_color;
    logic [9:0]  pru_col;
    logic [8:0]  pru_row;
    logic [9:0]  pru_width;
    logic [8:0]  pru_height_radius;
    logic [18:0] pru_bitmap_addr;
    logic        pru_busy = 1'b0;
    logic        pru_done = 1'b0;
    logic [$clog2(DEPTH):0] queue_count;
    logic        seq_idle;
    logic        err_timeout;
    logic [CNT_W-1:0] cmds_done;

    pru_cmd_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_shape         (cmd_shape),
        .cmd_color         (cmd_color),
        .cmd_col           (cmd_col),
        .cmd_row           (cmd_row),
        .cmd_width         (cmd_width),
        .cmd_height_radius (cmd_height_radius),
        .cmd_bitmap_addr   (cmd_bitmap_addr),
        .flush             (flush),
        .err_clr           (err_clr),
        .pru_start         (pru_start),
        .pru_shape_select  (pru_shape_select),
        .pru_color         (pru_color),
        .pru_col           (pru_col),
        .pru_row           (pru_row),
        .pru_width         (pru_width),
        .pru_height_radius (pru_height_radius),
        .pru_bitmap_addr   (pru_bitmap_addr),
        .pru_busy          (pru_busy),
        .pru_done          (pru_done),
        .queue_count       (queue_count),
        .seq_idle          (seq_idle),
        .err_timeout       (err_timeout),
        .cmds_done         (cmds_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: commands expected to be launched, in order, and the
    // number of commands expected to have completed since reset.
    pru_cmd_t exp_q[$];
    int       exp_done = 0;

    // PRU behaviour knobs.
    int done_delay = 25;
    int done_hold  = 0;
    bit never_done = 1'b0;
    bit stall      = 1'b0;

    // Monitor observations.
    int starts      = 0;
    int last_hi_len = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic pru_cmd_t mk(input int shape, input int col, input int row,
                                    input int width, input int hr);
        pru_cmd_t c;
        c.shape         = 2'(shape);
        c.color         = 2'(col + 1);
        c.col           = 10'(col);
        c.row           = 9'(row);
        c.width         = 10'(width);
        c.height_radius = 9'(hr);
        c.bitmap_addr   = 19'(col * 37 + row);
        return c;
    endfunction

    function automatic pru_cmd_t rand_cmd();
        pru_cmd_t c;
        c.shape         = 2'($urandom_range(0, 3));
        c.color         = 2'($urandom);
        c.col           = 10'($urandom);
        c.row           = 9'($urandom);
        c.width         = 10'($urandom);
        c.height_radius = 9'($urandom);
        c.bitmap_addr   = 19'($urandom);
        return c;
    endfunction

    function automatic pru_cmd_t observed();
        pru_cmd_t c;
        c.shape         = pru_shape_select;
        c.color         = pru_color;
        c.col           = pru_col;
        c.row           = pru_row;
        c.width         = pru_width;
        c.height_radius = pru_height_radius;
        c.bitmap_addr   = pru_bitmap_addr;
        return c;
    endfunction

    task automatic drive(input pru_cmd_t c);
        cmd_valid         = 1'b1;
        cmd_shape         = c.shape;
        cmd_color         = c.color;
        cmd_col           = c.col;
        cmd_row           = c.row;
        cmd_width         = c.width;
        cmd_height_radius = c.height_radius;
        cmd_bitmap_addr   = c.bitmap_addr;
    endtask

    // Called at a falling edge; holds the request until accepted or budget expires,
    // and returns at a falling edge with cmd_valid low.
    task automatic push_cmd(input pru_cmd_t c, input int budget);
        bit acc = 1'b0;
        drive(c);
        for (int i = 0; i < budget && !acc; i++) begin
            #1;
            acc = cmd_ready;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(c);
                exp_done++;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("push_accepted", 64'(acc), 1);
    endtask

    task automatic wait_start(input string name, input logic level, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(posedge clk);
            #3;
            hit = (pru_start == level);
        end
        check(name, 64'(hit), 1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(posedge clk);
            #3;
            hit = seq_idle && !pru_start && !pru_done;
        end
        check(name, 64'(hit), 1);
    endtask

    // PRU model: latches start, raises done done_delay cycles later, keeps
    // done for done_hold cycles after start falls, busy while engaged or stalled.
    initial begin
        bit started = 1'b0;
        int pcnt = 0;
        int hold_cnt = 0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                started  = 1'b0;
                pcnt     = 0;
                pru_done = 1'b0;
                pru_busy = 1'b0;
            end else begin
                if (pru_start && !started) begin
                    started = 1'b1;
                    pcnt    = 0;
                end
                if (started && pru_start) begin
                    pcnt++;
                    if (!never_done && pcnt == done_delay) pru_done = 1'b1;
                    hold_cnt = done_hold;
                end else if (started) begin
                    if (hold_cnt > 0) hold_cnt--;
                    else begin
                        pru_done = 1'b0;
                        started  = 1'b0;
                    end
                end
                pru_busy = stall || started;
            end
        end
    end

    // Monitor: every launch must match the oldest expected command, arrive with
    // done low, and keep its fields stable while start is high.
    initial begin
        logic     prev = 1'b0;
        bit       unstable = 1'b0;
        int       hi_len = 0;
        pru_cmd_t cur = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (pru_start && !prev) begin
                    starts++;
                    hi_len   = 1;
                    unstable = 1'b0;
                    check("launch_with_done_low", 64'(pru_done), 0);
                    check("launch_expected", 64'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        check("launch_fields", 64'(observed()), 64'(cur));
                    end
                end else if (pru_start) begin
                    hi_len++;
                    if (observed() != cur) unstable = 1'b1;
                end else if (prev) begin
                    last_hi_len = hi_len;
                    check("fields_stable", 64'(unstable), 0);
                end
                prev = pru_start;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pru_cmd_t cmds[9];
        pru_cmd_t c;
        int       s0;

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        check("rst_start", 64'(pru_start), 0);
        check("rst_qcount", 64'(queue_count), 0);
        check("rst_idle", 64'(seq_idle), 1);
        check("rst_err", 64'(err_timeout), 0);
        check("rst_cmds_done", 64'(cmds_done), 0);
        check("rst_fields", 64'(observed()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single rectangle: launch latency, field values, completion
        done_delay = 25;
        push_cmd(mk(0, 10, 20, 5, 4), 5);
        @(posedge clk);
        #1;
        check("t1_start_edge1", 64'(pru_start), 0);
        @(posedge clk);
        #1;
        check("t1_start_edge2", 64'(pru_start), 1);
        check("t1_shape", 64'(pru_shape_select), 0);
        check("t1_col", 64'(pru_col), 10);
        check("t1_row", 64'(pru_row), 20);
        check("t1_width", 64'(pru_width), 5);
        check("t1_height", 64'(pru_height_radius), 4);
        wait_start("t1_fall", 1'b0, 100);
        check("t1_hi_len", 64'(last_hi_len), 25);
        wait_idle("t1_idle", 20);
        check("t1_cmds_done", 64'(cmds_done), 64'(exp_done % (1 << CNT_W)));
        check("t1_err", 64'(err_timeout), 0);

        // Fill past DEPTH with the PRU stalled
        done_delay = 3;
        @(negedge clk);
        stall = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            cmds[i] = mk(i % 4, 100 + i, 7 * i, i + 1, 2 * i);
            drive(cmds[i]);
            #1;
            check("fill_ready", 64'(cmd_ready), 64'(i < DEPTH));
            if (i < DEPTH) begin
                @(posedge clk);
                exp_q.push_back(cmds[i]);
                exp_done++;
                @(negedge clk);
            end
        end
        check("fill_qcount", 64'(queue_count), DEPTH);
        check("fill_not_idle", 64'(seq_idle), 0);
        check("fill_no_start", 64'(pru_start), 0);
        @(negedge clk);
        stall = 1'b0;
        push_cmd(cmds[8], 100);
        wait_idle("fill_idle", 500);
        check("fill_drained", 64'(exp_q.size()), 0);
        check("fill_cmds_done", 64'(cmds_done), 64'(exp_done % (1 << CNT_W)));

        // Flush with a circle in flight and three queued
        done_delay = 40;
        @(negedge clk);
        s0 = starts;
        push_cmd(mk(1, 320, 240, 0, 50), 5);
        wait_start("flush_launch", 1'b1, 20);
        @(negedge clk);
        for (int i = 0; i < 3; i++) push_cmd(rand_cmd(), 5);
        check("flush_qcount_before", 64'(queue_count), 3);
        flush = 1'b1;
        drive(rand_cmd());
        #1;
        check("flush_ready_low", 64'(cmd_ready), 0);
        @(posedge clk);
        @(negedge clk);
        flush     = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) begin
            void'(exp_q.pop_back());
            exp_done--;
        end
        #1;
        check("flush_qcount_after", 64'(queue_count), 0);
        check("flush_inflight_start", 64'(pru_start), 1);
        wait_idle("flush_idle", 100);
        repeat (5) @(posedge clk);
        #3;
        check("flush_one_launch", 64'(starts - s0), 1);
        check("flush_cmds_done", 64'(cmds_done), 64'(exp_done % (1 << CNT_W)));

        // Done in the final timeout cycle counts as done
        done_delay = TIMEOUT;
        @(negedge clk);
        push_cmd(mk(2, 1, 2, 3, 4), 5);
        wait_start("edge_launch", 1'b1, 20);
        wait_start("edge_fall", 1'b0, 200);
        check("edge_hi_len", 64'(last_hi_len), TIMEOUT);
        check("edge_no_err", 64'(err_timeout), 0);
        wait_idle("edge_idle", 20);

        // Timeout abort, next command still launches, then clear the flag
        never_done = 1'b1;
        @(negedge clk);
        push_cmd(mk(0, 500, 100, 8, 8), 5);
        push_cmd(mk(3, 600, 200, 9, 9), 5);
        wait_start("tmo_launch", 1'b1, 20);
        wait_start("tmo_fall", 1'b0, 200);
        never_done = 1'b0;
        done_delay = 5;
        check("tmo_hi_len", 64'(last_hi_len), TIMEOUT);
        check("tmo_err_set", 64'(err_timeout), 1);
        wait_idle("tmo_idle", 100);
        check("tmo_drained", 64'(exp_q.size()), 0);
        check("tmo_err_sticky", 64'(err_timeout), 1);
        check("tmo_cmds_done", 64'(cmds_done), 64'(exp_done % (1 << CNT_W)));
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        check("tmo_err_cleared", 64'(err_timeout), 0);

        // PRU holds done after start falls; next launch must wait for done low
        done_delay = 4;
        done_hold  = 3;
        @(negedge clk);
        s0 = starts;
        push_cmd(mk(1, 11, 12, 0, 13), 5);
        push_cmd(mk(0, 21, 22, 23, 24), 5);
        wait_idle("hold_idle", 100);
        check("hold_two_launches", 64'(starts - s0), 2);
        done_hold = 0;

        // Reset in WAIT_DONE with four queued
        never_done = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) push_cmd(rand_cmd(), 5);
        check("rst_mid_qcount", 64'(queue_count), 4);
        wait_start("rst_mid_launch", 1'b1, 10);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_start", 64'(pru_start), 0);
        check("rst_mid_qcount_zero", 64'(queue_count), 0);
        check("rst_mid_idle", 64'(seq_idle), 1);
        check("rst_mid_cmds_done", 64'(cmds_done), 0);
        check("rst_mid_fields", 64'(observed()), 0);
        exp_q.delete();
        exp_done   = 0;
        never_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized traffic, enough to wrap cmds_done
        done_delay = $urandom_range(1, 12);
        done_hold  = $urandom_range(0, 2);
        for (int i = 0; i < 20; i++) begin
            c = rand_cmd();
            push_cmd(c, 200);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        wait_idle("rand_idle", 2000);
        check("rand_drained", 64'(exp_q.size()), 0);
        check("rand_cmds_done", 64'(cmds_done), 64'(exp_done % (1 << CNT_W)));
        check("rand_no_err", 64'(err_timeout), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
